// File: rtl/hms_clock_core.sv
// hms_clock_core: time-of-day counter (sec/min/hour) with a 1 Hz prescaler
// and a button-driven set mode, feeding the six-digit seven-segment path.
// Optional: define HMS_CLOCK_12H_EN for 12-hour operation with a PM flag
// shown on the leftmost decimal point while in CLOCK state.
module hms_clock_core #(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode,
  input  logic       i_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic [5:0] o_six_dp
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

`ifdef HMS_CLOCK_12H_EN
  localparam logic [4:0] HOUR_RST = 5'd12;
`else
  localparam logic [4:0] HOUR_RST = 5'd0;
`endif

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [5:0]       sec_n, min_n, dp_n;
  logic [4:0]       hour_n;
  logic             tick;
`ifdef HMS_CLOCK_12H_EN
  logic             pm, pm_n;
`endif

  // Sec/min wrap 59->0; anything above the limit also wraps to 0.
  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Hour wrap: 23->0 in 24-hour mode, 12->1 in 12-hour mode.
  function automatic logic [4:0] inc_hour(input logic [4:0] v);
`ifdef HMS_CLOCK_12H_EN
    return (v >= 5'd12) ? 5'd1 : v + 5'd1;
`else
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
`endif
  endfunction

  assign tick = (state == CLOCK) && (cnt == CNT_MAX);

  // Next-state, prescaler and time-field update; i_mode has priority over i_inc.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    sec_n   = o_sec;
    min_n   = o_min;
    hour_n  = o_hour;
`ifdef HMS_CLOCK_12H_EN
    pm_n    = pm;
`endif
    case (state)
      CLOCK: begin
        cnt_n = tick ? '0 : cnt + CNT_W'(1);
        if (i_mode) begin
          state_n = SET_SEC;
          cnt_n   = '0;
          sec_n   = 6'd0;
        end else if (tick) begin
          sec_n = inc60(o_sec);
          if (o_sec >= 6'd59) begin
            min_n = inc60(o_min);
            if (o_min >= 6'd59) begin
              hour_n = inc_hour(o_hour);
`ifdef HMS_CLOCK_12H_EN
              if (o_hour == 5'd11) pm_n = ~pm;
`endif
            end
          end
        end
      end
      SET_SEC: begin
        if (i_mode)     state_n = SET_MIN;
        else if (i_inc) sec_n   = inc60(o_sec);
      end
      SET_MIN: begin
        if (i_mode)     state_n = SET_HOUR;
        else if (i_inc) min_n   = inc60(o_min);
      end
      default: begin
        if (i_mode)     state_n = CLOCK;
        else if (i_inc) hour_n  = inc_hour(o_hour);
      end
    endcase

    case (state_n)
`ifdef HMS_CLOCK_12H_EN
      CLOCK:    dp_n = {pm_n, 5'b00000};
`else
      CLOCK:    dp_n = 6'b000000;
`endif
      SET_SEC:  dp_n = 6'b000011;
      SET_MIN:  dp_n = 6'b001100;
      default:  dp_n = 6'b110000;
    endcase
  end

  // State, prescaler, time and decimal-point registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLOCK;
      cnt      <= '0;
      o_sec    <= 6'd0;
      o_min    <= 6'd0;
      o_hour   <= HOUR_RST;
      o_six_dp <= 6'd0;
`ifdef HMS_CLOCK_12H_EN
      pm       <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      o_sec    <= sec_n;
      o_min    <= min_n;
      o_hour   <= hour_n;
      o_six_dp <= dp_n;
`ifdef HMS_CLOCK_12H_EN
      pm       <= pm_n;
`endif
    end
  end

  assign o_mode = state;

endmodule

// File: tb/tb_hms_clock_core.sv
// Testbench for hms_clock_core with CLK_DIV=4; expected snapshots are queued
// when stimulus is applied and popped/compared when the outputs are sampled.
module tb_hms_clock_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_mode = 1'b0;
  logic       i_inc = 1'b0;
  logic [5:0] o_sec, o_min, o_six_dp;
  logic [4:0] o_hour;
  logic [1:0] o_mode;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic [5:0] dp;
  } exp_t;

  exp_t sb[$];

  hms_clock_core #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_inc(i_inc),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_mode(o_mode), .o_six_dp(o_six_dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                         input logic [1:0] md, input logic [5:0] dp);
    exp_t e;
    e.sec = s; e.min = m; e.hour = h; e.mode = md; e.dp = dp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_sec"},  32'(o_sec),    32'(e.sec));
    chk({tag, "_min"},  32'(o_min),    32'(e.min));
    chk({tag, "_hour"}, 32'(o_hour),   32'(e.hour));
    chk({tag, "_mode"}, 32'(o_mode),   32'(e.mode));
    chk({tag, "_dp"},   32'(o_six_dp), 32'(e.dp));
  endtask

  // One cycle with the given inputs; returns at the negedge after its posedge.
  task automatic pulse(input logic m, input logic i);
    @(negedge clk); i_mode = m; i_inc = i;
    @(negedge clk); i_mode = 1'b0; i_inc = 1'b0;
  endtask

  // i_inc held high for n consecutive rising edges.
  task automatic hold_inc(input int n);
    @(negedge clk); i_inc = 1'b1;
    repeat (n) @(negedge clk);
    i_inc = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
`ifdef HMS_CLOCK_12H_EN
    sb_push(0, 0, 12, 0, 6'b000000); sb_check("reset");
    rst_n = 1'b1;
    pulse(1, 0);
    hold_inc(59);
    pulse(1, 0);
    hold_inc(59);
    pulse(1, 0);
    sb_push(59, 59, 12, 3, 6'b110000); sb_check("set_hour12");
    pulse(0, 1);
    sb_push(59, 59, 1, 3, 6'b110000); sb_check("hour_12_to_1");
    hold_inc(10);
    pulse(1, 0);
    sb_push(59, 59, 11, 0, 6'b000000); sb_check("clock_115959");
    repeat (3) @(negedge clk);
    sb_push(59, 59, 11, 0, 6'b000000); sb_check("pre_tick");
    @(negedge clk);
    sb_push(0, 0, 12, 0, 6'b100000); sb_check("pm_rollover");
    pulse(1, 0);
    pulse(1, 0);
    sb_push(0, 0, 12, 2, 6'b001100); sb_check("set_min");
    @(negedge clk); rst_n = 1'b0; #1;
    sb_push(0, 0, 12, 0, 6'b000000); sb_check("reset_mid");
`else
    sb_push(0, 0, 0, 0, 6'b000000); sb_check("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sb_push(0, 0, 0, 0, 6'b000000); sb_check("pre_first_tick");
    @(negedge clk);
    sb_push(1, 0, 0, 0, 6'b000000); sb_check("first_tick");
    repeat (4) @(negedge clk);
    sb_push(2, 0, 0, 0, 6'b000000); sb_check("second_tick");
    pulse(1, 0);
    sb_push(0, 0, 0, 1, 6'b000011); sb_check("enter_set_sec");
    repeat (10) @(negedge clk);
    sb_push(0, 0, 0, 1, 6'b000011); sb_check("frozen");
    hold_inc(59);
    sb_push(59, 0, 0, 1, 6'b000011); sb_check("sec59");
    pulse(1, 1);
    sb_push(59, 0, 0, 2, 6'b001100); sb_check("mode_wins");
    hold_inc(59);
    sb_push(59, 59, 0, 2, 6'b001100); sb_check("min59");
    pulse(0, 1);
    sb_push(59, 0, 0, 2, 6'b001100); sb_check("min_wrap_nocarry");
    hold_inc(59);
    pulse(1, 0);
    sb_push(59, 59, 0, 3, 6'b110000); sb_check("enter_set_hour");
    hold_inc(23);
    sb_push(59, 59, 23, 3, 6'b110000); sb_check("hour23");
    pulse(0, 1);
    sb_push(59, 59, 0, 3, 6'b110000); sb_check("hour_wrap");
    pulse(1, 0);
    sb_push(59, 59, 0, 0, 6'b000000); sb_check("back_to_clock");
    repeat (3) @(negedge clk);
    sb_push(59, 59, 0, 0, 6'b000000); sb_check("restart_pre");
    @(negedge clk);
    sb_push(0, 0, 1, 0, 6'b000000); sb_check("carry_to_hour");
    pulse(1, 0);
    hold_inc(59);
    pulse(1, 0);
    hold_inc(59);
    pulse(1, 0);
    hold_inc(22);
    pulse(1, 0);
    sb_push(59, 59, 23, 0, 6'b000000); sb_check("clock_235959");
    repeat (4) @(negedge clk);
    sb_push(0, 0, 0, 0, 6'b000000); sb_check("midnight");
    pulse(1, 0);
    pulse(1, 0);
    hold_inc(34);
    pulse(1, 0);
    hold_inc(12);
    sb_push(0, 34, 12, 3, 6'b110000); sb_check("set_123400");
    @(negedge clk); rst_n = 1'b0; #1;
    sb_push(0, 0, 0, 0, 6'b000000); sb_check("reset_mid");
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
